// File: rtl/axi_wb_pkg.sv
// Shared definitions for the Wishbone <-> AXI bridges: bridge FSM states,
// AXI response/burst/size encodings and a response classification helper.
package axi_wb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RD   = 3'd3,
        RW   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    // SLVERR and DECERR both have the upper response bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/wb2axi.sv
// Wishbone classic slave to AXI4 master bridge. Each 32-bit Wishbone access
// becomes one single-beat AXI transaction on a 64-bit data bus; only one
// transaction is ever outstanding.
// Optional feature macro: WB2AXI_ERR_EN -- when defined, SLVERR/DECERR
// responses terminate the Wishbone cycle with o_wb_err instead of o_wb_ack.
module wb2axi
    import axi_wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int IW = 1,
    parameter int ID = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic [AW-3:0]   i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic [3:0]      i_wb_sel,
    input  logic            i_wb_we,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    output logic [31:0]     o_wb_rdt,
    output logic            o_wb_ack,
    output logic            o_wb_err,

    output logic [AW-1:0]   o_awaddr,
    output logic [IW-1:0]   o_awid,
    output logic [7:0]      o_awlen,
    output logic [2:0]      o_awsize,
    output logic [1:0]      o_awburst,
    output logic            o_awvalid,
    input  logic            i_awready,

    output logic [63:0]     o_wdata,
    output logic [7:0]      o_wstrb,
    output logic            o_wlast,
    output logic            o_wvalid,
    input  logic            i_wready,

    input  logic [IW-1:0]   i_bid,
    input  logic [1:0]      i_bresp,
    input  logic            i_bvalid,
    output logic            o_bready,

    output logic [AW-1:0]   o_araddr,
    output logic [IW-1:0]   o_arid,
    output logic [7:0]      o_arlen,
    output logic [2:0]      o_arsize,
    output logic [1:0]      o_arburst,
    output logic            o_arvalid,
    input  logic            i_arready,

    input  logic [63:0]     i_rdata,
    input  logic [IW-1:0]   i_rid,
    input  logic [1:0]      i_rresp,
    input  logic            i_rlast,
    input  logic            i_rvalid,
    output logic            o_rready
);

    state_t state;
    logic   wb_live;
    logic   bresp_err;
    logic   rresp_err;
    logic   unused_ok;

    assign o_awid    = IW'(ID);
    assign o_arid    = IW'(ID);
    assign o_awlen   = 8'd0;
    assign o_arlen   = 8'd0;
    assign o_awsize  = SIZE_4B;
    assign o_arsize  = SIZE_4B;
    assign o_awburst = BURST_INCR;
    assign o_arburst = BURST_INCR;
    assign o_wlast   = 1'b1;

    // A master that has abandoned its cycle gets no termination pulse.
    assign wb_live = i_wb_cyc && i_wb_stb;

    // IDs and rlast carry no information for single-beat, single-ID traffic.
    assign unused_ok = ^{i_bid, i_rid, i_rlast, i_bresp, i_rresp};

`ifdef WB2AXI_ERR_EN
    logic err_q;

    assign bresp_err = resp_is_err(i_bresp);
    assign rresp_err = resp_is_err(i_rresp);

    // Error pulse is timed exactly like the ack pulse it replaces.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            err_q <= 1'b0;
        else
            err_q <= wb_live &&
                     (((state == WB) && i_bvalid && bresp_err) ||
                      ((state == RW) && i_rvalid && rresp_err));
    end

    assign o_wb_err = err_q;
`else
    assign bresp_err = 1'b0;
    assign rresp_err = 1'b0;
    assign o_wb_err  = 1'b0;
`endif

    // Transaction sequencer: launch on a fresh strobe, run the AXI handshakes,
    // then terminate the Wishbone cycle for exactly one clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_awvalid <= 1'b0;
            o_wvalid  <= 1'b0;
            o_bready  <= 1'b0;
            o_arvalid <= 1'b0;
            o_rready  <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_rdt  <= '0;
            o_awaddr  <= '0;
            o_araddr  <= '0;
            o_wdata   <= '0;
            o_wstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_live && !o_wb_ack) begin
                        if (i_wb_we) begin
                            state     <= WR;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            o_awaddr  <= {i_wb_adr, 2'b00};
                            o_wdata   <= {i_wb_dat, i_wb_dat};
                            o_wstrb   <= i_wb_adr[0] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
                        end else begin
                            state     <= RD;
                            o_arvalid <= 1'b1;
                            o_araddr  <= {i_wb_adr, 2'b00};
                        end
                    end
                end
                WR: begin
                    if (i_awready)
                        o_awvalid <= 1'b0;
                    if (i_wready)
                        o_wvalid <= 1'b0;
                    if ((!o_awvalid || i_awready) && (!o_wvalid || i_wready)) begin
                        state    <= WB;
                        o_bready <= 1'b1;
                    end
                end
                WB: begin
                    if (i_bvalid) begin
                        state    <= DONE;
                        o_bready <= 1'b0;
                        o_wb_ack <= wb_live && !bresp_err;
                    end
                end
                RD: begin
                    if (i_arready) begin
                        state     <= RW;
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                    end
                end
                RW: begin
                    if (i_rvalid) begin
                        state    <= DONE;
                        o_rready <= 1'b0;
                        o_wb_rdt <= o_araddr[2] ? i_rdata[63:32] : i_rdata[31:0];
                        o_wb_ack <= wb_live && !rresp_err;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    o_wb_ack <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb2axi.sv
// Self-checking bench for wb2axi. Acts as Wishbone master and AXI slave with
// per-transaction ready/response delays; termination pulses are scored
// against a queue of expected results. Honours WB2AXI_ERR_EN.
`timescale 1ns/1ps
module tb_wb2axi;
    import axi_wb_pkg::*;

    localparam int AW = 32;
    localparam int IW = 1;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [AW-3:0]   i_wb_adr = '0;
    logic [31:0]     i_wb_dat = '0;
    logic [3:0]      i_wb_sel = '0;
    logic            i_wb_we = 1'b0;
    logic            i_wb_cyc = 1'b0;
    logic            i_wb_stb = 1'b0;
    logic [31:0]     o_wb_rdt;
    logic            o_wb_ack;
    logic            o_wb_err;
    logic [AW-1:0]   o_awaddr;
    logic [IW-1:0]   o_awid;
    logic [7:0]      o_awlen;
    logic [2:0]      o_awsize;
    logic [1:0]      o_awburst;
    logic            o_awvalid;
    logic            i_awready = 1'b0;
    logic [63:0]     o_wdata;
    logic [7:0]      o_wstrb;
    logic            o_wlast;
    logic            o_wvalid;
    logic            i_wready = 1'b0;
    logic [IW-1:0]   i_bid = '0;
    logic [1:0]      i_bresp = '0;
    logic            i_bvalid = 1'b0;
    logic            o_bready;
    logic [AW-1:0]   o_araddr;
    logic [IW-1:0]   o_arid;
    logic [7:0]      o_arlen;
    logic [2:0]      o_arsize;
    logic [1:0]      o_arburst;
    logic            o_arvalid;
    logic            i_arready = 1'b0;
    logic [63:0]     i_rdata = '0;
    logic [IW-1:0]   i_rid = '0;
    logic [1:0]      i_rresp = '0;
    logic            i_rlast = 1'b0;
    logic            i_rvalid = 1'b0;
    logic            o_rready;

    always #5 i_clk = ~i_clk;

    wb2axi #(.AW(AW), .IW(IW), .ID(0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_awaddr(o_awaddr), .o_awid(o_awid), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arid(o_arid), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rid(i_rid), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    typedef struct {
        logic        exp_ack;
        logic        exp_err;
        logic        chk_rdt;
        logic [31:0] rdt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle_cnt = 0;
    int   aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic err_expected(input logic [1:0] resp);
`ifdef WB2AXI_ERR_EN
        return resp[1];
`else
        return 1'b0;
`endif
    endfunction

    // Cycle counter and AXI handshake counters.
    always @(posedge i_clk) begin
        cycle_cnt++;
        if (o_awvalid && i_awready) aw_hs++;
        if (o_wvalid && i_wready)   w_hs++;
        if (o_bready && i_bvalid)   b_hs++;
        if (o_arvalid && i_arready) ar_hs++;
        if (o_rready && i_rvalid)   r_hs++;
    end

    // Scoreboard: every termination pulse consumes one expected result.
    always @(negedge i_clk) begin
        if (i_rst_n && (o_wb_ack || o_wb_err)) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_term", {62'd0, o_wb_ack, o_wb_err}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("ack", {63'd0, o_wb_ack}, {63'd0, e.exp_ack});
                checkOutput("err", {63'd0, o_wb_err}, {63'd0, e.exp_err});
                if (e.chk_rdt)
                    checkOutput("rdt", {32'd0, o_wb_rdt}, {32'd0, e.rdt});
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int aw_dly, input int w_dly,
                                 input int resp_dly, input logic [1:0] resp,
                                 input logic [63:0] rdata, input bit drop_cyc, input int exp_lat);
        int          start, n;
        int          aw0, w0, b0, ar0, r0;
        logic [31:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [31:0] exp_rdt;
        exp_t        e;
        exp_addr  = {adr, 2'b00};
        exp_wdata = {dat, dat};
        exp_wstrb = exp_addr[2] ? {sel, 4'h0} : {4'h0, sel};
        exp_rdt   = exp_addr[2] ? rdata[63:32] : rdata[31:0];
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        if (!drop_cyc) begin
            e.exp_ack = !err_expected(resp);
            e.exp_err = err_expected(resp);
            e.chk_rdt = !we;
            e.rdt     = exp_rdt;
            sb_q.push_back(e);
        end
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_adr = adr;  i_wb_dat = dat;  i_wb_sel = sel;
        start = cycle_cnt;
        if (we) begin
            fork
                begin : aw_ch
                    int k;
                    k = 0;
                    @(negedge i_clk);
                    while (!o_awvalid && k < 20) begin @(negedge i_clk); k++; end
                    checkOutput("awvalid", {63'd0, o_awvalid}, 64'd1);
                    checkOutput("awaddr", {32'd0, o_awaddr}, {32'd0, exp_addr});
                    for (int j = 0; j < aw_dly; j++) begin
                        @(negedge i_clk);
                        checkOutput("aw_hold", {31'd0, o_awvalid, o_awaddr}, {31'd0, 1'b1, exp_addr});
                    end
                    i_awready = 1'b1;
                    @(negedge i_clk);
                    i_awready = 1'b0;
                    checkOutput("awvalid_drop", {63'd0, o_awvalid}, 64'd0);
                end
                begin : w_ch
                    int k;
                    k = 0;
                    @(negedge i_clk);
                    while (!o_wvalid && k < 20) begin @(negedge i_clk); k++; end
                    checkOutput("wvalid", {63'd0, o_wvalid}, 64'd1);
                    checkOutput("wdata", o_wdata, exp_wdata);
                    checkOutput("wstrb", {56'd0, o_wstrb}, {56'd0, exp_wstrb});
                    for (int j = 0; j < w_dly; j++) begin
                        @(negedge i_clk);
                        checkOutput("w_hold", o_wdata, exp_wdata);
                        checkOutput("w_hold_strb", {55'd0, o_wvalid, o_wstrb}, {55'd0, 1'b1, exp_wstrb});
                    end
                    i_wready = 1'b1;
                    @(negedge i_clk);
                    i_wready = 1'b0;
                    checkOutput("wvalid_drop", {63'd0, o_wvalid}, 64'd0);
                end
            join
            n = 0;
            while (!o_bready && n < 20) begin @(negedge i_clk); n++; end
            checkOutput("bready", {63'd0, o_bready}, 64'd1);
            if (drop_cyc) begin i_wb_cyc = 1'b0; i_wb_stb = 1'b0; end
            for (int j = 0; j < resp_dly; j++) @(negedge i_clk);
            i_bvalid = 1'b1; i_bresp = resp;
            @(negedge i_clk);
            i_bvalid = 1'b0; i_bresp = 2'b00;
            checkOutput("bready_drop", {63'd0, o_bready}, 64'd0);
        end else begin
            n = 0;
            @(negedge i_clk);
            while (!o_arvalid && n < 20) begin @(negedge i_clk); n++; end
            checkOutput("arvalid", {63'd0, o_arvalid}, 64'd1);
            checkOutput("araddr", {32'd0, o_araddr}, {32'd0, exp_addr});
            for (int j = 0; j < aw_dly; j++) begin
                @(negedge i_clk);
                checkOutput("ar_hold", {31'd0, o_arvalid, o_araddr}, {31'd0, 1'b1, exp_addr});
            end
            i_arready = 1'b1;
            @(negedge i_clk);
            i_arready = 1'b0;
            checkOutput("arvalid_drop", {63'd0, o_arvalid}, 64'd0);
            n = 0;
            while (!o_rready && n < 20) begin @(negedge i_clk); n++; end
            checkOutput("rready", {63'd0, o_rready}, 64'd1);
            if (drop_cyc) begin i_wb_cyc = 1'b0; i_wb_stb = 1'b0; end
            for (int j = 0; j < resp_dly; j++) @(negedge i_clk);
            i_rvalid = 1'b1; i_rdata = rdata; i_rresp = resp; i_rlast = 1'b1;
            @(negedge i_clk);
            i_rvalid = 1'b0; i_rresp = 2'b00; i_rlast = 1'b0;
            checkOutput("rready_drop", {63'd0, o_rready}, 64'd0);
        end
        if (!drop_cyc) begin
            n = 0;
            while (!(o_wb_ack || o_wb_err) && n < 4) begin @(negedge i_clk); n++; end
            checkOutput("term_seen", {63'd0, o_wb_ack | o_wb_err}, 64'd1);
            if (exp_lat >= 0)
                checkOutput("latency", 64'(cycle_cnt - start), 64'(exp_lat));
            i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
            @(negedge i_clk);
            checkOutput("term_one_cycle", {63'd0, o_wb_ack | o_wb_err}, 64'd0);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checkOutput("abort_no_term", {63'd0, o_wb_ack | o_wb_err}, 64'd0);
                @(negedge i_clk);
            end
        end
        checkOutput("aw_count", 64'(aw_hs - aw0), we ? 64'd1 : 64'd0);
        checkOutput("w_count",  64'(w_hs - w0),   we ? 64'd1 : 64'd0);
        checkOutput("b_count",  64'(b_hs - b0),   we ? 64'd1 : 64'd0);
        checkOutput("ar_count", 64'(ar_hs - ar0), we ? 64'd0 : 64'd1);
        checkOutput("r_count",  64'(r_hs - r0),   we ? 64'd0 : 64'd1);
    endtask

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        #1;
        checkOutput("reset_valids", {57'd0, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wb_ack, o_wb_err}, 64'd0);
        checkOutput("reset_addr", {o_awaddr, o_araddr}, 64'd0);
        checkOutput("reset_wdata", o_wdata, 64'd0);
        checkOutput("reset_rdt_strb", {24'd0, o_wb_rdt, o_wstrb}, 64'd0);
        checkOutput("const_fields", {45'd0, o_awlen, o_awsize, o_awburst, o_wlast, o_awid},
                    {45'd0, 8'd0, SIZE_4B, BURST_INCR, 1'b1, 1'b0});
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] directed writes and reads, zero-wait slave");
        applyStimulus(1'b1, 30'h104, 32'hA5A5_1234, 4'hF, 0, 0, 0, RESP_OKAY, 64'd0, 1'b0, 3);
        applyStimulus(1'b1, 30'h105, 32'hDEAD_BEEF, 4'h5, 0, 0, 0, RESP_OKAY, 64'd0, 1'b0, 3);
        applyStimulus(1'b0, 30'h101, 32'd0, 4'hF, 0, 0, 0, RESP_OKAY, 64'h1122_3344_5566_7788, 1'b0, 3);
        applyStimulus(1'b0, 30'h100, 32'd0, 4'hF, 0, 0, 0, RESP_OKAY, 64'h1122_3344_5566_7788, 1'b0, 3);

        $display("[TB] back-pressure, zero byte selects, error responses");
        applyStimulus(1'b1, 30'h2A7, 32'h0BAD_F00D, 4'h9, 6, 2, 2, RESP_OKAY, 64'd0, 1'b0, -1);
        applyStimulus(1'b1, 30'h002, 32'h1357_9BDF, 4'h0, 1, 0, 1, RESP_OKAY, 64'd0, 1'b0, -1);
        applyStimulus(1'b0, 30'h033, 32'd0, 4'hF, 1, 0, 2, RESP_SLVERR, 64'hCAFE_0001_BEEF_0002, 1'b0, -1);
        applyStimulus(1'b1, 30'h040, 32'h2468_ACE0, 4'h3, 0, 3, 0, RESP_DECERR, 64'd0, 1'b0, -1);

        $display("[TB] abort during read response wait");
        applyStimulus(1'b0, 30'h0F1, 32'd0, 4'hF, 0, 0, 5, RESP_OKAY, 64'h0123_4567_89AB_CDEF, 1'b1, -1);
        applyStimulus(1'b0, 30'h003, 32'd0, 4'hF, 0, 0, 0, RESP_OKAY, 64'hFEED_FACE_0000_1111, 1'b0, 3);

        $display("[TB] randomised transfers");
        for (int t = 0; t < 6; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), 30'($urandom_range(0, 1023)), $urandom,
                          4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), 2'b00, {$urandom, $urandom}, 1'b0, -1);
        end

        $display("[TB] reset while waiting for the write response");
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_adr = 30'h077; i_wb_dat = 32'h5555_AAAA; i_wb_sel = 4'hF;
        @(negedge i_clk);
        i_awready = 1'b1; i_wready = 1'b1;
        @(negedge i_clk);
        i_awready = 1'b0; i_wready = 1'b0;
        n = 0;
        while (!o_bready && n < 20) begin @(negedge i_clk); n++; end
        checkOutput("rst_pre_bready", {63'd0, o_bready}, 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valids", {57'd0, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wb_ack, o_wb_err}, 64'd0);
        checkOutput("rst_async_awaddr", {32'd0, o_awaddr}, 64'd0);
        checkOutput("rst_async_wdata", o_wdata, 64'd0);
        checkOutput("rst_async_wstrb", {56'd0, o_wstrb}, 64'd0);
        checkOutput("rst_const", {61'd0, o_awsize}, {61'd0, SIZE_4B});
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        applyStimulus(1'b0, 30'h055, 32'd0, 4'hF, 0, 0, 0, RESP_OKAY, 64'hA1B2_C3D4_E5F6_0718, 1'b0, 3);

        repeat (3) @(negedge i_clk);
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
